// File: rtl/tsu_drain_pkg.sv
// Shared definitions for the PTP timestamp-queue drain scheduler:
// FSM state encoding, queue count, holdoff counter width and the
// queue-index to stream-tag mapping.
package tsu_drain_pkg;

  localparam int NUM_Q  = 8;
  localparam int HOLD_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    CAP  = 2'd2,
    OUT  = 2'd3
  } state_t;

  // Queues 0-3 are TX ports 0-3, queues 4-7 are RX ports 0-3.
  // Tag is {dir (1 = TX), port[1:0]}.
  function automatic logic [2:0] q_to_tag(input logic [2:0] q);
    return {~q[2], q[1:0]};
  endfunction

endpackage

// File: rtl/tsu_drain_sched_rr_arb8.sv
// Combinational 8-way round-robin pick: the first requesting index
// strictly after the last-grant pointer, wrapping 7 -> 0.
module rr_arb8
  import tsu_drain_pkg::*;
(
  input  logic [NUM_Q-1:0] req_i,
  input  logic [2:0]       last_i,
  output logic [2:0]       gnt_o,
  output logic             gnt_vld_o
);

  logic [2:0] idx;

  // Scan last+1 .. last+8; the first hit wins.
  always_comb begin
    gnt_o     = '0;
    gnt_vld_o = 1'b0;
    idx       = '0;
    for (int i = 1; i <= NUM_Q; i++) begin
      idx = last_i + 3'(i);
      if (!gnt_vld_o && req_i[idx]) begin
        gnt_o     = idx;
        gnt_vld_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tsu_drain_sched.sv
// Drains the eight PTP timestamp queues (4 TX, 4 RX) into one tagged
// AXI-Stream, one entry per IDLE->RD->CAP->OUT pass.
// Optional feature macro: TSU_DRAIN_TX_PRIO_EN gives TX queues strict
// priority over RX, with separate round-robin pointers per group.
//
// Output handshake: m_tdata/m_tuser are held stable while m_tvalid=1 and
// a transfer happens on the first cycle where m_tvalid and m_tready are
// both high; m_tready may rise before m_tvalid.
module tsu_drain_sched
  import tsu_drain_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int HOLDOFF   = 4,
  parameter int DATA_W    = 128
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic [8*NUM_PORTS-1:0]      tx_q_stat_flat,
  input  logic [8*NUM_PORTS-1:0]      rx_q_stat_flat,
  input  logic [DATA_W*NUM_PORTS-1:0] tx_q_data_flat,
  input  logic [DATA_W*NUM_PORTS-1:0] rx_q_data_flat,
  output logic [NUM_PORTS-1:0]        tx_q_rd_en,
  output logic [NUM_PORTS-1:0]        rx_q_rd_en,
  output logic [DATA_W-1:0]           m_tdata,
  output logic [2:0]                  m_tuser,
  output logic                        m_tvalid,
  input  logic                        m_tready,
  output logic [31:0]                 drained_cnt,
  output logic                        busy,
  output logic [1:0]                  dbg_state
);

  state_t              state_q, state_d;
  logic [2:0]          grant_q, grant_d;
  logic [DATA_W-1:0]   m_tdata_q, m_tdata_d;
  logic [2:0]          m_tuser_q, m_tuser_d;
  logic                m_tvalid_q, m_tvalid_d;
  logic [31:0]         cnt_q, cnt_d;
  logic [HOLD_W-1:0]   hold_q [NUM_Q];
  logic [HOLD_W-1:0]   hold_d [NUM_Q];
  logic [NUM_Q-1:0]    req;
  logic [DATA_W-1:0]   tx_data [NUM_PORTS];
  logic [DATA_W-1:0]   rx_data [NUM_PORTS];
  logic [2:0]          pick;
  logic                pick_vld;
  logic                hs;
  logic                unused_stat;

  // Only bit 0 of each status byte carries meaning.
  assign unused_stat = ^{tx_q_stat_flat, rx_q_stat_flat};

  // Eligibility per queue and unpacking of the flat data buses.
  always_comb begin
    req = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      req[p]             = tx_q_stat_flat[8*p] && (hold_q[p] == '0);
      req[NUM_PORTS + p] = rx_q_stat_flat[8*p] && (hold_q[NUM_PORTS + p] == '0);
      tx_data[p]         = tx_q_data_flat[p*DATA_W +: DATA_W];
      rx_data[p]         = rx_q_data_flat[p*DATA_W +: DATA_W];
    end
  end

  assign hs = (state_q == OUT) && m_tvalid_q && m_tready;

`ifdef TSU_DRAIN_TX_PRIO_EN
  logic [2:0] tx_last_q, rx_last_q;
  logic [2:0] tx_gnt, rx_gnt;
  logic       tx_vld, rx_vld;

  rr_arb8 u_arb_tx (
    .req_i     ({4'b0000, req[3:0]}),
    .last_i    (tx_last_q),
    .gnt_o     (tx_gnt),
    .gnt_vld_o (tx_vld)
  );

  rr_arb8 u_arb_rx (
    .req_i     ({req[7:4], 4'b0000}),
    .last_i    (rx_last_q),
    .gnt_o     (rx_gnt),
    .gnt_vld_o (rx_vld)
  );

  assign pick     = tx_vld ? tx_gnt : rx_gnt;
  assign pick_vld = tx_vld | rx_vld;

  // Per-group pointers; reset values make queue 0 / queue 4 first.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_last_q <= 3'd3;
      rx_last_q <= 3'd7;
    end else if (hs) begin
      if (grant_q[2]) rx_last_q <= grant_q;
      else            tx_last_q <= grant_q;
    end
  end
`else
  logic [2:0] last_q;

  rr_arb8 u_arb (
    .req_i     (req),
    .last_i    (last_q),
    .gnt_o     (pick),
    .gnt_vld_o (pick_vld)
  );

  // Single ring pointer; reset to 7 so queue 0 is served first.
  always_ff @(posedge clk) begin
    if (rst)     last_q <= 3'd7;
    else if (hs) last_q <= grant_q;
  end
`endif

  // Next-state and datapath for the drain FSM.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    m_tdata_d  = m_tdata_q;
    m_tuser_d  = m_tuser_q;
    m_tvalid_d = m_tvalid_q;
    cnt_d      = cnt_q;
    case (state_q)
      IDLE: begin
        if (en && pick_vld) begin
          grant_d = pick;
          state_d = RD;
        end
      end
      RD: state_d = CAP;
      CAP: begin
        m_tdata_d  = grant_q[2] ? rx_data[grant_q[1:0]] : tx_data[grant_q[1:0]];
        m_tuser_d  = q_to_tag(grant_q);
        m_tvalid_d = 1'b1;
        state_d    = OUT;
      end
      OUT: begin
        if (hs) begin
          m_tvalid_d = 1'b0;
          cnt_d      = cnt_q + 32'd1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Holdoff counters tick down every cycle; the just-drained queue reloads.
  always_comb begin
    for (int i = 0; i < NUM_Q; i++) begin
      hold_d[i] = (hold_q[i] != '0) ? hold_q[i] - HOLD_W'(1) : hold_q[i];
    end
    if (hs) hold_d[grant_q] = HOLD_W'(HOLDOFF);
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      m_tdata_q  <= '0;
      m_tuser_q  <= '0;
      m_tvalid_q <= 1'b0;
      cnt_q      <= '0;
      for (int i = 0; i < NUM_Q; i++) hold_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      m_tdata_q  <= m_tdata_d;
      m_tuser_q  <= m_tuser_d;
      m_tvalid_q <= m_tvalid_d;
      cnt_q      <= cnt_d;
      for (int i = 0; i < NUM_Q; i++) hold_q[i] <= hold_d[i];
    end
  end

  // The read pulse is the RD state itself, so it lasts exactly one cycle.
  assign tx_q_rd_en  = (state_q == RD && !grant_q[2]) ? (NUM_PORTS'(1) << grant_q[1:0]) : '0;
  assign rx_q_rd_en  = (state_q == RD &&  grant_q[2]) ? (NUM_PORTS'(1) << grant_q[1:0]) : '0;
  assign m_tdata     = m_tdata_q;
  assign m_tuser     = m_tuser_q;
  assign m_tvalid    = m_tvalid_q;
  assign drained_cnt = cnt_q;
  assign busy        = (state_q != IDLE);
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_tsu_drain_sched.sv
// Bench for tsu_drain_sched: transaction-level model checked every
// cycle plus directed scenarios with hand-computed expectations.
// Honours TSU_DRAIN_TX_PRIO_EN if defined for the build.
module tb_tsu_drain_sched;

  localparam int NP      = 4;
  localparam int DW      = 128;
  localparam int HOLDOFF = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic              en, m_tready;
  logic [NP-1:0]     tx_av, rx_av;
  logic [8*NP-1:0]   tx_q_stat_flat, rx_q_stat_flat;
  logic [DW*NP-1:0]  tx_q_data_flat, rx_q_data_flat;
  logic [NP-1:0]     tx_q_rd_en, rx_q_rd_en;
  logic [DW-1:0]     m_tdata;
  logic [2:0]        m_tuser;
  logic              m_tvalid;
  logic [31:0]       drained_cnt;
  logic              busy;
  logic [1:0]        dbg_state;

  tsu_drain_sched #(.NUM_PORTS(NP), .HOLDOFF(HOLDOFF), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .en(en),
    .tx_q_stat_flat(tx_q_stat_flat), .rx_q_stat_flat(rx_q_stat_flat),
    .tx_q_data_flat(tx_q_data_flat), .rx_q_data_flat(rx_q_data_flat),
    .tx_q_rd_en(tx_q_rd_en), .rx_q_rd_en(rx_q_rd_en),
    .m_tdata(m_tdata), .m_tuser(m_tuser), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .drained_cnt(drained_cnt), .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- queue-side stimulus ----------------
  // Queue data changes every cycle: top byte A0+q identifies the queue,
  // low word is the cycle number, so a mistimed capture shows up.
  int            cyc = 0;
  logic [DW-1:0] src_data [8];

  initial begin
    for (int q = 0; q < 8; q++) src_data[q] = '0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      for (int q = 0; q < 8; q++) src_data[q] = {8'hA0 | 8'(q), 88'h0, 32'(cyc)};
    end
  end

  always_comb begin
    for (int p = 0; p < NP; p++) begin
      tx_q_stat_flat[p*8 +: 8] = {7'h55, tx_av[p]};
      rx_q_stat_flat[p*8 +: 8] = {7'h55, rx_av[p]};
      tx_q_data_flat[p*DW +: DW] = src_data[p];
      rx_q_data_flat[p*DW +: DW] = src_data[4+p];
    end
  end

  // ---------------- scoreboard bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;
  bit chk_on   = 1'b0;
  logic [2:0] exp_q[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // One entry in flight; m_age counts cycles since it was granted
  // (0 = nothing in flight, 1 = read pulse, 2 = data on the bus,
  // 3 = entry offered downstream).
  int          m_age = 0;
  int          m_grant = 0;
  int          m_last = 7, m_last_tx = 3, m_last_rx = 7;
  int          m_hold [8];
  logic [DW-1:0] m_tdata_e = '0;
  logic [2:0]  m_tuser_e = '0;
  logic [31:0] m_cnt = '0;

  function automatic bit q_ready(input int q);
    bit av;
    av = (q < 4) ? tx_av[q] : rx_av[q-4];
    return av && (m_hold[q] == 0);
  endfunction

  function automatic int model_pick();
    int res;
    res = -1;
`ifdef TSU_DRAIN_TX_PRIO_EN
    for (int k = 1; k <= 4; k++)
      if (res < 0 && q_ready((m_last_tx + k) % 4)) res = (m_last_tx + k) % 4;
    for (int k = 1; k <= 4; k++)
      if (res < 0 && q_ready(4 + (m_last_rx - 4 + k) % 4)) res = 4 + (m_last_rx - 4 + k) % 4;
`else
    for (int k = 1; k <= 8; k++)
      if (res < 0 && q_ready((m_last + k) % 8)) res = (m_last + k) % 8;
`endif
    return res;
  endfunction

  always @(posedge clk) begin : model
    int pick;
    if (rst) begin
      m_age = 0; m_last = 7; m_last_tx = 3; m_last_rx = 7;
      m_tdata_e = '0; m_tuser_e = '0; m_cnt = '0;
      for (int i = 0; i < 8; i++) m_hold[i] = 0;
    end else begin
      pick = model_pick();
      for (int i = 0; i < 8; i++) if (m_hold[i] > 0) m_hold[i]--;
      if (m_age == 0) begin
        if (en && pick >= 0) begin m_grant = pick; m_age = 1; end
      end else if (m_age == 1) begin
        m_age = 2;
      end else if (m_age == 2) begin
        m_tdata_e = src_data[m_grant];
        m_tuser_e = {(m_grant < 4) ? 1'b1 : 1'b0, 2'(m_grant % 4)};
        m_age = 3;
      end else if (m_tready) begin
        m_cnt++;
        m_last = m_grant;
        if (m_grant < 4) m_last_tx = m_grant; else m_last_rx = m_grant;
        m_hold[m_grant] = HOLDOFF;
        m_age = 0;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin : compare
    logic [NP-1:0] e_tx, e_rx;
    if (chk_on) begin
      e_tx = (m_age == 1 && m_grant < 4)  ? NP'(1) << m_grant       : '0;
      e_rx = (m_age == 1 && m_grant >= 4) ? NP'(1) << (m_grant - 4) : '0;
      check("tx_rd_en", 128'(tx_q_rd_en), 128'(e_tx));
      check("rx_rd_en", 128'(rx_q_rd_en), 128'(e_rx));
      check("m_tvalid", 128'(m_tvalid), 128'(m_age == 3));
      check("m_tuser", 128'(m_tuser), 128'(m_tuser_e));
      check("m_tdata", m_tdata, m_tdata_e);
      check("drained_cnt", 128'(drained_cnt), 128'(m_cnt));
      check("busy", 128'(busy), 128'(m_age != 0));
      check("rd_en_onehot", 128'($countones({tx_q_rd_en, rx_q_rd_en}) <= 1), 128'(1));
      check("rd_en_while_valid", 128'((|{tx_q_rd_en, rx_q_rd_en}) && m_tvalid), 128'(0));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic idle_inputs();
    en = 1'b0; m_tready = 1'b0; tx_av = '0; rx_av = '0;
  endtask

  // Waits up to budget negedges for a read pulse; idx = queue or -1.
  task automatic wait_rd(input int budget, output int idx);
    idx = -1;
    for (int c = 0; c < budget && idx < 0; c++) begin
      @(negedge clk);
      for (int p = 0; p < NP; p++) begin
        if (tx_q_rd_en[p]) idx = p;
        if (rx_q_rd_en[p]) idx = 4 + p;
      end
    end
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- directed scenarios ----------------
  initial begin : stim
    int idx, prev, hit, c1, c2;
    logic [DW-1:0] d0;
    logic [2:0] u0;

    idle_inputs();
    rst = 1'b1;
    @(posedge clk); #1;
    do_reset();
    chk_on = 1'b1;

    // Reset state
    @(negedge clk);
    check("rst_tvalid", 128'(m_tvalid), 128'(0));
    check("rst_tdata", m_tdata, 128'(0));
    check("rst_tuser", 128'(m_tuser), 128'(0));
    check("rst_cnt", 128'(drained_cnt), 128'(0));
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_rd_en", 128'({tx_q_rd_en, rx_q_rd_en}), 128'(0));

    // T1: only RX port 2 available, ready high
    idle_inputs(); do_reset();
    rx_av = 4'b0100; en = 1'b1; m_tready = 1'b1;
    @(negedge clk); check("t1_rd_n", 128'(rx_q_rd_en), 128'(0));
    @(negedge clk); check("t1_rd_n1", 128'(rx_q_rd_en), 128'(4'b0100));
                    check("t1_tx_n1", 128'(tx_q_rd_en), 128'(0));
    @(negedge clk); check("t1_rd_n2", 128'(rx_q_rd_en), 128'(0));
    @(negedge clk); check("t1_tvalid_n3", 128'(m_tvalid), 128'(1));
                    check("t1_tuser_n3", 128'(m_tuser), 128'(3'b010));
                    check("t1_tdata_q", 128'(m_tdata[127:120]), 128'(8'hA6));
    @(negedge clk); check("t1_cnt", 128'(drained_cnt), 128'(1));
                    check("t1_tvalid_off", 128'(m_tvalid), 128'(0));
    hit = -1;
    for (int k = 5; k <= 30 && hit < 0; k++) begin
      @(negedge clk);
      if (rx_q_rd_en != '0) hit = k;
    end
    check("t1_regrant_gap", 128'(hit), 128'(9));
    rx_av = '0;
    repeat (6) @(posedge clk);

    // T2: all queues permanently available
    idle_inputs(); do_reset();
`ifdef TSU_DRAIN_TX_PRIO_EN
    exp_q = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0, 3'd1, 3'd2, 3'd3, 3'd0};
`else
    exp_q = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};
`endif
    tx_av = 4'hF; rx_av = 4'hF; en = 1'b1; m_tready = 1'b1;
    prev = -1;
    while (exp_q.size() > 0) begin
      wait_rd(12, idx);
      check("t2_order", 128'(idx), 128'(exp_q.pop_front()));
      if (idx < 0) break;
      if (prev >= 0) check("t2_spacing", 128'(cyc - prev), 128'(4));
      prev = cyc;
    end
    idle_inputs();
    repeat (6) @(posedge clk);

    // T3: backpressure in OUT
    do_reset();
    tx_av = 4'b0001; en = 1'b1; m_tready = 1'b0;
    hit = 0;
    for (int c = 0; c < 10 && !hit; c++) begin
      @(negedge clk);
      if (m_tvalid) hit = 1;
    end
    check("t3_tvalid_seen", 128'(hit), 128'(1));
    d0 = m_tdata; u0 = m_tuser;
    check("t3_tuser", 128'(u0), 128'(3'b100));
    check("t3_tdata_q", 128'(d0[127:120]), 128'(8'hA0));
    tx_av = '0;
    repeat (10) begin
      @(negedge clk);
      check("t3_hold_tdata", m_tdata, d0);
      check("t3_hold_tuser", 128'(m_tuser), 128'(u0));
      check("t3_hold_tvalid", 128'(m_tvalid), 128'(1));
      check("t3_no_rd", 128'({tx_q_rd_en, rx_q_rd_en}), 128'(0));
    end
    m_tready = 1'b1;
    @(negedge clk);
    check("t3_release_tvalid", 128'(m_tvalid), 128'(0));
    check("t3_release_cnt", 128'(drained_cnt), 128'(1));
    repeat (5) @(negedge clk);
    check("t3_single_hs", 128'(drained_cnt), 128'(1));

    // T4: en dropped during RD
    idle_inputs(); do_reset();
    rx_av = 4'b0010; en = 1'b1; m_tready = 1'b1;
    wait_rd(10, idx);
    check("t4_first_rd", 128'(idx), 128'(5));
    en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("t4_tvalid", 128'(m_tvalid), 128'(1));
    check("t4_tuser", 128'(m_tuser), 128'(3'b001));
    @(negedge clk);
    check("t4_cnt", 128'(drained_cnt), 128'(1));
    repeat (20) begin
      @(negedge clk);
      check("t4_no_rd", 128'({tx_q_rd_en, rx_q_rd_en}), 128'(0));
      check("t4_idle", 128'(busy), 128'(0));
    end
    en = 1'b1;
    wait_rd(10, idx);
    check("t4_resume", 128'(idx), 128'(5));
    idle_inputs();
    repeat (6) @(posedge clk);

    // T5: reset asserted in CAP
    do_reset();
    tx_av = 4'hF; rx_av = 4'hF; en = 1'b1; m_tready = 1'b1;
    hit = 0;
    for (int c = 0; c < 40 && !hit; c++) begin
      @(negedge clk);
      if (tx_q_rd_en == 4'b0100) hit = 1;
    end
    check("t5_reach_q2", 128'(hit), 128'(1));
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("t5_tvalid", 128'(m_tvalid), 128'(0));
    check("t5_tdata", m_tdata, 128'(0));
    check("t5_tuser", 128'(m_tuser), 128'(0));
    check("t5_cnt", 128'(drained_cnt), 128'(0));
    check("t5_busy", 128'(busy), 128'(0));
    check("t5_rd", 128'({tx_q_rd_en, rx_q_rd_en}), 128'(0));
    @(negedge clk);
    check("t5_first_grant", 128'(tx_q_rd_en), 128'(4'b0001));
    idle_inputs();
    repeat (6) @(posedge clk);

    // T6: TX1 and RX0 both available
    do_reset();
    tx_av = 4'b0010; rx_av = 4'b0001; en = 1'b1; m_tready = 1'b1;
    wait_rd(10, c1);
    check("t6_first", 128'(c1), 128'(1));
    wait_rd(10, c2);
    check("t6_second", 128'(c2), 128'(4));
    idle_inputs();
    repeat (8) @(posedge clk);

    // Report
    chk_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tsu_drain_sched.md
# tsu_drain_sched

Round-robin scheduler that drains the eight PTP timestamp queues (4 TX, 4 RX, one per MAC port) into a single tagged AXI-Stream. The block owns the queue read side and replaces per-queue software polling through the register block. Downstream consumers are a DMA or a CPU-facing FIFO. Queue read clocks must be tied to `clk` at the top level.

## Interface
Parameters:
- `NUM_PORTS`, 4: MAC ports. Queue count is `2*NUM_PORTS`.
- `HOLDOFF`, 4: cycles a queue is ineligible after being read, so its cross-domain status can settle. Range 1–15.
- `DATA_W`, 128: timestamp queue entry width.

Ports:
- `clk` in 1: sole clock; queue read clock.
- `rst` in 1: synchronous, active-high reset.
- `en` in 1: scheduling enable.
- `tx_q_stat_flat` in 8*NUM_PORTS: per-queue status. Bit 0 of each byte = entry available. Other bits are ignored.
- `rx_q_stat_flat` in 8*NUM_PORTS: same layout as `tx_q_stat_flat`.
- `tx_q_data_flat` in DATA_W*NUM_PORTS: queue read data. Valid the cycle after `rd_en`.
- `rx_q_data_flat` in DATA_W*NUM_PORTS: same timing as `tx_q_data_flat`.
- `tx_q_rd_en` out NUM_PORTS: one-cycle read pulse.
- `rx_q_rd_en` out NUM_PORTS: one-cycle read pulse.
- `m_tdata` out DATA_W: drained timestamp entry.
- `m_tuser` out 3: {dir (1 = TX), port[1:0]}.
- `m_tvalid` out 1: output valid.
- `m_tready` in 1: output ready.
- `drained_cnt` out 32: entries delivered. Wraps modulo 2^32.
- `busy` out 1: high whenever state ≠ IDLE.

## Operation
Queue index q is 0–7: 0–3 are TX ports 0–3, 4–7 are RX ports 0–3.

Eligibility: q is eligible when `stat[q][0]`=1 and `holdoff_cnt[q]`=0.

State machine:
- IDLE: if `en` and any queue is eligible, the arbiter picks the first eligible index after `last_grant`, wrapping 7→0. The index is latched into `grant` and the state goes to RD.
- RD: assert the `rd_en` bit for `grant` for exactly one cycle. Go to CAP.
- CAP: register the selected queue data into `m_tdata` and the tag into `m_tuser`. Set `m_tvalid`. Go to OUT.
- OUT: hold `m_tdata`, `m_tuser` and `m_tvalid` stable until `m_tready`=1. On the handshake:
  - clear `m_tvalid`;
  - increment `drained_cnt`;
  - set `last_grant`=`grant`;
  - load `holdoff_cnt[grant]`=HOLDOFF;
  - go to IDLE.

Holdoff counters decrement by one per cycle while nonzero, in every state.

Enable behaviour:
- `en` is sampled only in IDLE.
- Deasserting `en` mid-transaction completes the current entry.

Other rules:
- At most one `rd_en` bit is high in any cycle.
- `rd_en` is never issued while `m_tvalid`=1.
- A status bit that drops between grant and RD does not cancel the read. The entry delivered is whatever the queue presents.

## Timing
Reset values:
- State = IDLE.
- All `rd_en` = 0, `m_tvalid` = 0, `m_tdata` = 0, `m_tuser` = 0.
- `drained_cnt` = 0, `busy` = 0.
- `last_grant` = 7, so queue 0 is first after reset.
- All holdoff counters = 0.

Latency and throughput:
- With eligibility seen in IDLE at cycle n: `rd_en` at n+1, data sampled at n+2, `m_tvalid` high at n+3.
- Back-to-back with `m_tready` held high: one entry per 4 cycles.
- `m_tready` may be high before `m_tvalid`. The handshake occurs on the first cycle both are high.

Boundary conditions:
- `rst` in any state aborts immediately. A pulse already issued is not repeated, and the entry is lost by design.
- A single eligible queue is re-granted no sooner than HOLDOFF cycles after its handshake.
- All queues eligible: grant order is 0,1,…,7,0.

## Configuration
- `TSU_DRAIN_TX_PRIO_EN` defined: TX queues (0–3) have strict priority over RX (4–7). Round-robin applies within each group, with separate `last_grant` pointers.
- Undefined: a single round-robin ring over all 8 queues, as described above.

## Structure
- Package `tsu_drain_pkg` holds:
  - the state enum: IDLE, RD, CAP, OUT;
  - `NUM_Q` = 8;
  - the queue-index-to-tag mapping function: index → {dir, port};
  - the holdoff counter width, 4 bits.
- Sub-module `rr_arb8`: combinational 8-way round-robin pick.
  - Inputs: request vector, last-grant pointer.
  - Outputs: grant index, grant valid.
  - Instantiated once, or twice under `TSU_DRAIN_TX_PRIO_EN`.

## Test plan
- Reset, then only RX port 2 has data, `m_tready`=1 → `rx_q_rd_en`=4'b0100 for one cycle at n+1. `m_tuser`=3'b010 and `m_tvalid` at n+3. `drained_cnt`=1.
- All 8 queues permanently available, `m_tready`=1, HOLDOFF=4 → grant order 0–7 repeating, 4-cycle spacing, no cycle with two `rd_en` bits.
- Backpressure: `m_tready`=0 for 10 cycles in OUT → `m_tdata` and `m_tuser` stable, no further `rd_en`. Release → single handshake.
- `en` dropped during RD → current entry completes. No new grant while `en`=0.
- `rst` asserted in CAP → all outputs at reset values the next cycle. The first grant after reset is queue 0.
- With `TSU_DRAIN_TX_PRIO_EN`: TX1 and RX0 both available → TX1 served first. RX0 served only when no TX queue is eligible.
